// File: rtl/iir_out_packer.sv
// iir_out_packer: output stage behind the 8th-order IIR filter.
// Rescales each 17-bit filter result to an 8-bit lane with saturation,
// packs LANES lanes per word and buffers words in a FIFO drained through
// a valid/ready handshake. The first SKIP accepted samples after reset
// (filter pipeline fill) are discarded.
// Build option: define IIR_PACK_ROUND_EN for round-half-up rescaling;
// the default build truncates.
module iir_out_packer #(
  parameter int unsigned DIN_W = 17,
  parameter int unsigned SHIFT = 9,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKIP  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DIN_W-1:0]            in_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*OUT_W-1:0]      out_data,
  output logic                        out_last,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        sat,
  output logic                        overflow,
  output logic                        busy
);

  localparam int unsigned WORD_W = LANES * OUT_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned LCW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SKW    = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

  localparam logic [LCW-1:0]   LANE_LAST = LCW'(LANES - 1);
  localparam logic [SKW-1:0]   SKIP_LAST = SKW'((SKIP == 0) ? 0 : SKIP - 1);
  localparam logic [DIN_W:0]   Y_MAX     = (DIN_W + 1)'((1 << OUT_W) - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

  localparam logic ST_WARM  = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  localparam logic ST_RESET = (SKIP == 0) ? ST_RUN : ST_WARM;

  // ---------------------------------------------------------------------
  // Warm-up control
  // ---------------------------------------------------------------------
  logic           state;
  logic [SKW-1:0] skip_cnt;
  logic           run;

  assign run = (state == ST_RUN);

  // Count and discard filter pipeline-fill samples, then enter RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      skip_cnt <= '0;
    end else if (state == ST_WARM && in_valid) begin
      skip_cnt <= skip_cnt + SKW'(1);
      if (skip_cnt == SKIP_LAST) begin
        state <= ST_RUN;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: rescale and saturate
  // ---------------------------------------------------------------------
  logic [DIN_W:0]   y_wide;
  logic             y_sat;
  logic [OUT_W-1:0] y_byte;

`ifdef IIR_PACK_ROUND_EN
  localparam logic [DIN_W:0] ROUND_BIAS =
    (SHIFT == 0) ? '0 : ((DIN_W + 1)'(1) << (SHIFT - 1));
`endif

  // Rescale one sample at DIN_W+1 bits so the rounding add cannot wrap.
  always_comb begin
`ifdef IIR_PACK_ROUND_EN
    y_wide = ({1'b0, in_data} + ROUND_BIAS) >> SHIFT;
`else
    y_wide = {1'b0, in_data} >> SHIFT;
`endif
    y_sat  = (y_wide > Y_MAX);
    y_byte = y_sat ? '1 : y_wide[OUT_W-1:0];
  end

  logic             s1_valid;
  logic             s1_flush;
  logic [OUT_W-1:0] s1_data;

  // Register the lane value; the flush marker travels alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_data  <= '0;
      sat      <= 1'b0;
    end else begin
      s1_valid <= run && in_valid;
      s1_flush <= run && flush;
      if (run && in_valid) begin
        s1_data <= y_byte;
        if (y_sat) begin
          sat <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: lane packing
  // ---------------------------------------------------------------------
  logic [LCW-1:0]    lane_cnt;
  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] pack_nxt;
  logic [LCW-1:0]    cnt_nxt;
  logic              word_full;
  logic              pk_push;

  logic              push_v;
  logic [WORD_W-1:0] push_word;
  logic              push_last;

  // Merge the incoming lane, then decide whether a word leaves this cycle.
  // A flush marker is applied after its own sample: it pushes whatever is
  // held once that sample has been merged, so a completing sample yields
  // one word tagged last and an empty pack yields nothing.
  always_comb begin
    pack_nxt  = pack;
    cnt_nxt   = lane_cnt;
    word_full = 1'b0;
    if (s1_valid) begin
      pack_nxt[lane_cnt*OUT_W +: OUT_W] = s1_data;
      if (lane_cnt == LANE_LAST) begin
        word_full = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = lane_cnt + LCW'(1);
      end
    end
    pk_push = word_full || (s1_flush && (s1_valid || (lane_cnt != '0)));
  end

  // Hold the partial word and register the outgoing word for the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= '0;
      pack      <= '0;
      push_v    <= 1'b0;
      push_word <= '0;
      push_last <= 1'b0;
    end else begin
      push_v <= pk_push;
      if (pk_push) begin
        push_word <= pack_nxt;
        push_last <= s1_flush;
        lane_cnt  <= '0;
        pack      <= '0;
      end else begin
        lane_cnt <= cnt_nxt;
        pack     <= pack_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] mem      [DEPTH];
  logic              mem_last [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_next;
  logic [CW-1:0]     count;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;
  logic [WORD_W-1:0] head_nxt;
  logic              head_last_nxt;

  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign pop        = out_valid && out_ready;
  assign full       = (count == FULL_CNT);
  assign wr_en      = push_v && (!full || pop);
  assign drop       = push_v && full && !pop;
  assign rd_next    = rd_ptr + AW'(1);

  // Next head word: the registered output always mirrors the oldest entry,
  // including a word written into an empty (or emptying) FIFO this cycle.
  always_comb begin
    head_nxt      = out_data;
    head_last_nxt = out_last;
    if (pop) begin
      if (count == CW'(1)) begin
        if (wr_en) begin
          head_nxt      = push_word;
          head_last_nxt = push_last;
        end
      end else begin
        head_nxt      = mem[rd_next];
        head_last_nxt = mem_last[rd_next];
      end
    end else if (count == '0 && wr_en) begin
      head_nxt      = push_word;
      head_last_nxt = push_last;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]      <= push_word;
      mem_last[wr_ptr] <= push_last;
    end
  end

  // Pointers, occupancy, head register and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      count <= count + CW'(wr_en) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
      out_data <= head_nxt;
      out_last <= head_last_nxt;
    end
  end

  assign busy = s1_valid || (lane_cnt != '0) || push_v || (count != '0);

endmodule

// File: tb/tb_iir_out_packer.sv
// Directed self-checking bench for iir_out_packer (default parameters),
// plus a second instance with SHIFT=8, SKIP=0, DEPTH=2 where a full-scale
// input saturates in either build.
module tb_iir_out_packer;

`ifdef IIR_PACK_ROUND_EN
  localparam logic [31:0] RND_EXP  = 32'h02010001;
  localparam logic        SAT_FULL = 1'b1;
`else
  localparam logic [31:0] RND_EXP  = 32'h01010000;
  localparam logic        SAT_FULL = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [16:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  fifo_count;
  logic        sat;
  logic        overflow;
  logic        busy;

  logic        v2 = 1'b0;
  logic [16:0] d2 = '0;
  logic        flush2 = 1'b0;
  logic        ready2 = 1'b0;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_last2;
  logic [1:0]  fifo_count2;
  logic        sat2;
  logic        overflow2;
  logic        busy2;

  iir_out_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .fifo_count(fifo_count),
    .sat(sat), .overflow(overflow), .busy(busy)
  );

  iir_out_packer #(.SHIFT(8), .SKIP(0), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2),
    .flush(flush2), .out_valid(out_valid2), .out_ready(ready2),
    .out_data(out_data2), .out_last(out_last2), .fifo_count(fifo_count2),
    .sat(sat2), .overflow(overflow2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Word whose four lanes all equal k: samples k*512.
  task automatic send_word(input int unsigned k);
    for (int unsigned i = 0; i < 4; i++) send(17'(k * 512));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_sat", sat, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Second instance: no warm-up, full-scale input saturates.
    chk("d2_sat_reset", sat2, 0);
    v2 = 1'b1; d2 = 17'h1FFFF;
    tick(); tick(); tick(); tick();
    v2 = 1'b0;
    tick(); tick();
    chk("d2_valid", out_valid2, 1);
    chk("d2_word", out_data2, 32'hFFFFFFFF);
    chk("d2_last", out_last2, 0);
    chk("d2_count", fifo_count2, 1);
    chk("d2_sat", sat2, 1);
    ready2 = 1'b1; tick(); ready2 = 1'b0;
    chk("d2_count_drained", fifo_count2, 0);
    chk("d2_overflow", overflow2, 0);
    chk("d2_busy", busy2, 0);

    // Warm-up: two dropped samples, then one word.
    send(17'd1000);
    send(17'd2000);
    send(17'd512);
    send(17'd1024);
    send(17'd1536);
    send(17'd2048);
    chk("warm_not_yet", out_valid, 0);
    tick();
    chk("warm_t1_not_yet", out_valid, 0);
    tick();
    chk("warm_valid", out_valid, 1);
    chk("warm_word", out_data, 32'h04030201);
    chk("warm_last", out_last, 0);
    chk("warm_count", fifo_count, 1);
    chk("warm_busy", busy, 1);
    tick();
    chk("warm_stable", out_data, 32'h04030201);
    pop();
    chk("warm_drained", out_valid, 0);
    chk("warm_sat_clear", sat, 0);

    // Rounding versus truncation.
    send(17'd256);
    send(17'd255);
    send(17'd767);
    send(17'd768);
    tick(); tick();
    chk("round_word", out_data, RND_EXP);
    pop();

    // Full scale: 255 either way; saturates only when rounding.
    send_word(0);
    for (int unsigned i = 0; i < 4; i++) send(17'h1FFFF);
    tick(); tick();
    chk("sat_word_zero", out_data, 32'h00000000);
    pop();
    chk("sat_word_ff", out_data, 32'hFFFFFFFF);
    chk("sat_flag", sat, SAT_FULL);
    pop();
    tick(); tick();
    chk("sat_flag_sticky", sat, SAT_FULL);

    // Flush after two samples.
    send(17'd512);
    send(17'd1024);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("flush_t1_not_yet", out_valid, 0);
    tick();
    chk("flush_valid", out_valid, 1);
    chk("flush_word", out_data, 32'h00000201);
    chk("flush_last", out_last, 1);
    pop();
    // Flush with nothing held.
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick(); tick();
    chk("flush_empty_count", fifo_count, 0);
    chk("flush_empty_busy", busy, 0);

    // Flush on the sample that completes a word: one word, last=1.
    send(17'd512);
    send(17'd1024);
    send(17'd1536);
    in_valid = 1'b1; in_data = 17'd2048; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("flush_full_word", out_data, 32'h04030201);
    chk("flush_full_last", out_last, 1);
    chk("flush_full_count", fifo_count, 1);
    pop();
    tick();
    chk("flush_full_no_extra", fifo_count, 0);

    // Flush on a partial sample: sample packed first, then padded.
    send(17'd512);
    in_valid = 1'b1; in_data = 17'd1024; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("flush_co_word", out_data, 32'h00000201);
    chk("flush_co_last", out_last, 1);
    pop();

    // Overflow: nine words into an eight-deep FIFO with no drain.
    for (int unsigned k = 1; k <= 9; k++) send_word(k);
    tick(); tick();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    for (int unsigned k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain%0d", k), out_data, {4{8'(k)}});
      pop();
    end
    chk("ovf_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Same, but a pop coincides with the ninth push.
    reset_dut();
    chk("rst2_overflow", overflow, 0);
    chk("rst2_sat", sat, 0);
    send(17'd7);
    send(17'd7);
    for (int unsigned k = 1; k <= 9; k++) send_word(k);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pp_count", fifo_count, 8);
    chk("full_pp_overflow", overflow, 0);
    for (int unsigned k = 2; k <= 9; k++) begin
      chk($sformatf("full_pp_drain%0d", k), out_data, {4{8'(k)}});
      pop();
    end
    chk("full_pp_empty", fifo_count, 0);

    // Reset mid-word discards the partial word.
    send(17'd512);
    send(17'd1024);
    send(17'd1536);
    reset_dut();
    chk("rst3_busy", busy, 0);
    chk("rst3_d2_sat", sat2, 0);
    send(17'd9999);
    send(17'd9999);
    send(17'd2560);
    send(17'd3072);
    send(17'd3584);
    send(17'd4096);
    tick(); tick(); tick();
    chk("rst3_count", fifo_count, 1);
    chk("rst3_word", out_data, 32'h08070605);
    pop();
    chk("rst3_drained", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
